// File: rtl/avmm_rd_burst_master_if.sv
// Avalon-MM bus bundle shared by the read burst master and its slave.
interface avalonMM_iface #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned BURST_WIDTH = 4
);
  logic                    if_rd;
  logic                    if_wr;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic [BURST_WIDTH-1:0]  if_burst_c;
  logic [DATA_WIDTH-1:0]   if_wrdata;
  logic [DATA_WIDTH/8-1:0] if_byteen;
  logic                    if_waitreq;
  logic [DATA_WIDTH-1:0]   if_rddata;
  logic                    if_rddata_vld;

  modport master (
    output if_rd, if_wr, if_addr, if_burst_c, if_wrdata, if_byteen,
    input  if_waitreq, if_rddata, if_rddata_vld
  );

  modport slave (
    input  if_rd, if_wr, if_addr, if_burst_c, if_wrdata, if_byteen,
    output if_waitreq, if_rddata, if_rddata_vld
  );
endinterface

// File: rtl/avmm_rd_burst_master.sv
// Read DMA front-end: splits (addr, len) commands into credit-gated Avalon-MM
// read bursts and streams returned beats out of an FWFT FIFO.
module avmm_rd_burst_master #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ADDR_WIDTH  = 22,
  parameter int unsigned BURST_WIDTH = 4,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_vld,
  output logic                  o_cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  avalonMM_iface.master         m_avmm,
  output logic                  o_dat_vld,
  input  logic                  i_dat_rdy,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_dat_last,
  output logic                  o_busy
);
  localparam int unsigned MAX_BURST = 2 ** (BURST_WIDTH - 1);
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned SW        = CW + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_e;

  function automatic logic [BURST_WIDTH-1:0] min_burst(input logic [LEN_WIDTH-1:0] r);
    if (r >= LEN_WIDTH'(MAX_BURST)) return BURST_WIDTH'(MAX_BURST);
    return r[BURST_WIDTH-1:0];
  endfunction

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic                   rd_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [LEN_WIDTH-1:0]   rcv_q;
  logic [CW-1:0]          out_q;
  logic [CW-1:0]          cnt_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [DATA_WIDTH-1:0]  dat_mem [FIFO_DEPTH];
  logic                   last_mem [FIFO_DEPTH];

  logic                   push;
  logic                   pop;
  logic                   accept;
  logic                   push_last;
  logic [LEN_WIDTH-1:0]   rcv_nxt;
  logic [LEN_WIDTH-1:0]   rem_acc;
  logic [BURST_WIDTH-1:0] b_acc;
  logic [BURST_WIDTH-1:0] b_cmd;
  logic [SW-1:0]          used;
  logic                   credit_cmd;
  logic                   credit_hold;
  logic                   credit_next;

  // Credit uses this cycle's occupancy; it can only shrink by the next edge,
  // so every check is conservative. credit_next also covers the burst being
  // accepted right now so the follow-on burst can go out back-to-back.
  always_comb begin
    push        = m_avmm.if_rddata_vld && (out_q != '0);
    pop         = o_dat_vld && i_dat_rdy;
    accept      = rd_q && !m_avmm.if_waitreq;
    push_last   = (rcv_q + LEN_WIDTH'(1)) == len_q;
    rcv_nxt     = rcv_q + LEN_WIDTH'(push);
    rem_acc     = rem_q - LEN_WIDTH'(burst_q);
    b_acc       = min_burst(rem_acc);
    b_cmd       = min_burst(i_cmd_len);
    used        = SW'(cnt_q) + SW'(out_q);
    credit_cmd  = (used + SW'(b_cmd)) <= SW'(FIFO_DEPTH);
    credit_hold = (used + SW'(burst_q)) <= SW'(FIFO_DEPTH);
    credit_next = (used + SW'(burst_q) + SW'(b_acc)) <= SW'(FIFO_DEPTH);
  end

  // Command FSM and burst issue; rd/addr/burst only move on acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      burst_q <= '0;
      rd_q    <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
      rcv_q   <= '0;
    end else begin
      rcv_q <= rcv_nxt;
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_vld && (i_cmd_len != '0)) begin
            addr_q  <= i_cmd_addr;
            len_q   <= i_cmd_len;
            rem_q   <= i_cmd_len;
            rcv_q   <= '0;
            burst_q <= b_cmd;
            rd_q    <= credit_cmd;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            addr_q  <= addr_q + ADDR_WIDTH'(burst_q);
            rem_q   <= rem_acc;
            burst_q <= b_acc;
            if (rem_acc == '0) begin
              rd_q    <= 1'b0;
              state_q <= ST_DRAIN;
            end else begin
              rd_q <= credit_next;
            end
          end else if (!rd_q) begin
            rd_q <= credit_hold;
          end
        end
        ST_DRAIN: begin
          if (rcv_nxt == len_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding-beat and FIFO occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      out_q <= out_q + (accept ? CW'(burst_q) : CW'(0)) - CW'(push);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      dat_mem[wr_ptr_q]  <= m_avmm.if_rddata;
      last_mem[wr_ptr_q] <= push_last;
    end
  end

  assign o_dat_vld  = (cnt_q != '0);
  assign o_dat      = o_dat_vld ? dat_mem[rd_ptr_q] : '0;
  assign o_dat_last = o_dat_vld && last_mem[rd_ptr_q];
  assign o_cmd_rdy  = (state_q == ST_IDLE);
  assign o_busy     = (state_q != ST_IDLE);

  assign m_avmm.if_rd      = rd_q;
  assign m_avmm.if_wr      = 1'b0;
  assign m_avmm.if_addr    = addr_q;
  assign m_avmm.if_burst_c = burst_q;
  assign m_avmm.if_wrdata  = '0;
  assign m_avmm.if_byteen  = '1;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_avmm_rd_burst_master.sv
// Scoreboard bench for avmm_rd_burst_master: reference model predicts bursts
// and beats per command, monitors compare against the bus and the stream.
module tb_avmm_rd_burst_master;
  localparam int unsigned DW    = 512;
  localparam int unsigned AW    = 22;
  localparam int unsigned BW    = 4;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int          MAXB  = 8;
  localparam int          NW    = DW / 32;

  typedef struct packed { logic [AW-1:0] addr; logic [BW-1:0] cnt; } burst_t;
  typedef struct packed { logic [DW-1:0] d; logic last; } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_vld = 1'b0;
  logic          cmd_rdy;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          dat_vld;
  logic          dat_rdy;
  logic [DW-1:0] dat;
  logic          dat_last;
  logic          busy;

  always #5 clk = ~clk;

  avalonMM_iface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) m_if ();

  avmm_rd_burst_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_vld(cmd_vld), .o_cmd_rdy(cmd_rdy),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .m_avmm(m_if),
    .o_dat_vld(dat_vld), .i_dat_rdy(dat_rdy), .o_dat(dat), .o_dat_last(dat_last),
    .o_busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int inflight = 0;
  int acc_bursts = 0;
  int acc_cyc_q[$];
  burst_t exp_burst_q[$];
  beat_t  exp_beat_q[$];
  logic [AW-1:0] ret_addr_q[$];

  bit rnd_mode = 1'b0;
  bit hold_ret = 1'b0;
  int rdy_mode = 1;
  int stall_at = -1;
  int stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < NW; i++)
      d[i*32 +: 32] = ({10'd0, a} * 32'h9E37_79B1) ^ (32'(i) * 32'h0101_0101);
    return d;
  endfunction

  // Reference model: split a command into bursts and beats.
  task automatic model_push(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [AW-1:0] p = a;
    int r = int'(l);
    int k = 0;
    int b;
    while (r > 0) begin
      b = (r > MAXB) ? MAXB : r;
      exp_burst_q.push_back('{addr: p, cnt: BW'(b)});
      for (int i = 0; i < b; i++)
        exp_beat_q.push_back('{d: beat_data(p + AW'(i)), last: (k + i == int'(l) - 1)});
      k += b;
      p = p + AW'(b);
      r -= b;
    end
  endtask

  // Slave / downstream stimulus: drives waitreq, read data and dat_rdy on negedges.
  initial begin
    logic [AW-1:0] a;
    m_if.if_waitreq    = 1'b0;
    m_if.if_rddata_vld = 1'b0;
    m_if.if_rddata     = '0;
    dat_rdy            = 1'b0;
    forever begin
      @(negedge clk);
      dat_rdy = (rdy_mode == 2) ? ($urandom_range(1) == 1) : (rdy_mode == 1);
      if (rst) begin
        ret_addr_q.delete();
        m_if.if_rddata_vld = 1'b0;
        m_if.if_waitreq    = 1'b0;
        continue;
      end
      if (ret_addr_q.size() > 0 && !hold_ret && (!rnd_mode || $urandom_range(3) != 0)) begin
        a = ret_addr_q.pop_front();
        m_if.if_rddata     = beat_data(a);
        m_if.if_rddata_vld = 1'b1;
      end else begin
        m_if.if_rddata     = '0;
        m_if.if_rddata_vld = 1'b0;
      end
      if (m_if.if_rd && stall_left > 0 && acc_bursts == stall_at) begin
        m_if.if_waitreq = 1'b1;
        stall_left--;
      end else begin
        m_if.if_waitreq = rnd_mode ? ($urandom_range(3) == 0) : 1'b0;
      end
      if (m_if.if_rd && !m_if.if_waitreq) begin
        for (int i = 0; i < int'(m_if.if_burst_c); i++)
          ret_addr_q.push_back(m_if.if_addr + AW'(i));
        acc_bursts++;
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // Bus monitor: burst order/content, waitreq hold stability, credit bound.
  initial begin
    bit            prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [BW-1:0] prev_cnt  = '0;
    burst_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_wait = 1'b0;
        continue;
      end
      if (prev_wait) begin
        chkb("hold_rd", m_if.if_rd, 1'b1);
        chkn("hold_addr", int'(m_if.if_addr), int'(prev_addr));
        chkn("hold_burst", int'(m_if.if_burst_c), int'(prev_cnt));
      end
      prev_wait = m_if.if_rd && m_if.if_waitreq;
      prev_addr = m_if.if_addr;
      prev_cnt  = m_if.if_burst_c;
      if (m_if.if_rd && !m_if.if_waitreq) begin
        if (exp_burst_q.size() == 0) begin
          fail("burst_unexpected", $sformatf("addr 0x%0h cnt %0d", m_if.if_addr, m_if.if_burst_c));
        end else begin
          e = exp_burst_q.pop_front();
          chkn("burst_addr", int'(m_if.if_addr), int'(e.addr));
          chkn("burst_cnt", int'(m_if.if_burst_c), int'(e.cnt));
        end
        inflight += int'(m_if.if_burst_c);
        chkb("credit", inflight <= int'(DEPTH), 1'b1);
      end
    end
  end

  // Stream monitor: beat data and last marker in order.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && dat_vld && dat_rdy) begin
        inflight--;
        if (exp_beat_q.size() == 0) begin
          fail("beat_unexpected", $sformatf("data %0h", dat[31:0]));
        end else begin
          e = exp_beat_q.pop_front();
          chkd("beat_data", dat, e.d);
          chkb("beat_last", dat_last, e.last);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    cmd_vld  = 1'b1;
    cmd_addr = a;
    cmd_len  = l;
    while (!cmd_rdy && n < 2000) begin
      step();
      n++;
    end
    if (!cmd_rdy) fail("cmd_timeout", "o_cmd_rdy never rose");
    else model_push(a, l);
    step();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_beat_q.size() != 0 || !cmd_rdy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail("drain_timeout", $sformatf("%0d beats still expected", exp_beat_q.size()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [AW-1:0] ra;
    repeat (3) step();
    chkb("rst_cmd_rdy", cmd_rdy, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_dat_vld", dat_vld, 1'b0);
    chkb("rst_dat_last", dat_last, 1'b0);
    chkd("rst_dat", dat, '0);
    chkb("rst_rd", m_if.if_rd, 1'b0);
    chkb("rst_wr", m_if.if_wr, 1'b0);
    chkn("rst_addr", int'(m_if.if_addr), 0);
    chkn("rst_burst", int'(m_if.if_burst_c), 0);
    chkd("rst_wrdata", m_if.if_wrdata, '0);
    chkb("rst_byteen", &m_if.if_byteen, 1'b1);
    rst = 1'b0;
    step();

    // Single beat with exact cycle timing.
    issue(AW'(32'h100), LW'(1));
    chkb("t1_rd_next", m_if.if_rd, 1'b1);
    chkn("t1_addr", int'(m_if.if_addr), 32'h100);
    chkn("t1_burst", int'(m_if.if_burst_c), 1);
    chkb("t1_busy", busy, 1'b1);
    step();
    chkb("t1_rdy_before", cmd_rdy, 1'b0);
    step();
    chkb("t1_rdy_after", cmd_rdy, 1'b1);
    chkb("t1_dat_vld", dat_vld, 1'b1);
    chkb("t1_last", dat_last, 1'b1);
    wait_done(100);

    // len=20: three bursts, first two back-to-back.
    base = acc_bursts;
    acc_cyc_q.delete();
    issue(AW'(32'h200), LW'(20));
    wait_done(500);
    chkn("t2_bursts", acc_bursts - base, 3);
    if (acc_cyc_q.size() >= 2) chkn("t2_back_to_back", acc_cyc_q[1] - acc_cyc_q[0], 1);

    // Same command, second burst stalled 5 cycles.
    base = acc_bursts;
    stall_at = acc_bursts + 1;
    stall_left = 5;
    issue(AW'(32'h200), LW'(20));
    wait_done(500);
    chkn("t3_bursts", acc_bursts - base, 3);
    chkn("t3_stall_used", stall_left, 0);
    stall_at = -1;

    // Full backpressure: credit allows exactly two bursts into a 16-deep FIFO.
    rdy_mode = 0;
    base = acc_bursts;
    issue(AW'(32'h1000), LW'(40));
    repeat (40) step();
    chkn("t4_bursts_blocked", acc_bursts - base, 2);
    chkb("t4_rd_low", m_if.if_rd, 1'b0);
    chkb("t4_dat_vld", dat_vld, 1'b1);
    rdy_mode = 1;
    wait_done(1000);
    chkn("t4_bursts_total", acc_bursts - base, 5);

    // Zero-length command is a no-op.
    base = acc_bursts;
    issue(AW'(32'h55), LW'(0));
    chkb("t5_cmd_rdy", cmd_rdy, 1'b1);
    chkb("t5_busy", busy, 1'b0);
    chkb("t5_rd", m_if.if_rd, 1'b0);
    repeat (3) step();
    chkn("t5_no_bursts", acc_bursts - base, 0);

    // Reset with 3 beats outstanding.
    hold_ret = 1'b1;
    issue(AW'(32'h300), LW'(3));
    n = 0;
    while (ret_addr_q.size() < 3 && n < 50) begin
      step();
      n++;
    end
    chkn("t6_outstanding", ret_addr_q.size(), 3);
    chkb("t6_no_data", dat_vld, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_ret = 1'b0;
    exp_burst_q.delete();
    exp_beat_q.delete();
    inflight = 0;
    chkb("t6_cmd_rdy", cmd_rdy, 1'b1);
    chkb("t6_busy", busy, 1'b0);
    chkb("t6_dat_vld", dat_vld, 1'b0);
    chkb("t6_rd", m_if.if_rd, 1'b0);
    issue(AW'(32'h400), LW'(4));
    wait_done(200);

    // Randomized commands, waitreq, return gaps and backpressure.
    rnd_mode = 1'b1;
    for (int c = 0; c < 30; c++) begin
      rdy_mode = ($urandom_range(2) == 0) ? 1 : 2;
      ra = ($urandom_range(3) == 0) ? AW'(22'h3F_FFF0 + 22'($urandom_range(15))) : AW'($urandom);
      issue(ra, LW'($urandom_range(40)));
      if ($urandom_range(3) == 0) wait_done(3000);
    end
    wait_done(5000);
    chkn("end_bursts_left", exp_burst_q.size(), 0);
    chkn("end_inflight", inflight, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/avmm_rd_burst_master.md
# avmm_rd_burst_master

Read DMA front-end that drives an `avalonMM_iface.master` port. It takes a (word address, beat count) command and splits it into Avalon-MM read bursts. Returned read data is buffered in an internal FIFO and presented downstream as a valid/ready stream with a last-beat marker. Issue is credit-gated, so returned data never overflows the FIFO, even under full downstream backpressure.

## Interface
- DATA_WIDTH, 512, data bus width; must match the interface instance.
- ADDR_WIDTH, 22, word address width; must match the interface instance.
- BURST_WIDTH, 4, burstcount width; MAX_BURST = 2**(BURST_WIDTH-1) = 8 beats.
- LEN_WIDTH, 16, command length width in beats.
- FIFO_DEPTH, 64, read-data FIFO depth in beats; power of two, ≥ MAX_BURST.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_cmd_vld  in  1  command valid.
- o_cmd_rdy  out  1  command ready; high only in IDLE.
- i_cmd_addr  in  ADDR_WIDTH  start word address.
- i_cmd_len  in  LEN_WIDTH  number of beats; 0 is legal and is a no-op.
- m_avmm  master modport  avalonMM_iface.master  Avalon-MM read master.
- o_dat_vld  out  1  stream data valid.
- i_dat_rdy  in  1  stream data ready.
- o_dat  out  DATA_WIDTH  read data beat.
- o_dat_last  out  1  final beat of the command; qualified by o_dat_vld.
- o_busy  out  1  high in ISSUE or DRAIN.

## Operation
- if_wr is tied 0. if_wrdata is tied 0. if_byteen is all ones.
- Addressing is in words. Each burst advances the address by its burst count.
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE:**
  - o_cmd_rdy = 1.
  - On i_cmd_vld with len = 0: accept the command, stay in IDLE, generate no traffic.
  - On i_cmd_vld with len > 0: latch addr and len, set rem = len and rcv = 0, go to ISSUE.
- **ISSUE:**
  - Burst size is b = min(rem, MAX_BURST).
  - Credit check: fifo_cnt + outstanding + b ≤ FIFO_DEPTH. outstanding = beats requested but not yet returned.
  - if_rd is asserted only while credit is met.
  - Once if_rd is high, if_rd, if_addr and if_burst_c are held stable until the cycle with if_waitreq = 0.
  - On acceptance (if_rd & !if_waitreq):
    - addr += b; rem -= b; outstanding += b.
    - If rem becomes 0, go to DRAIN.
- **DRAIN:**
  - Wait until rcv == len, then go to IDLE.
  - FIFO contents may still be pending downstream. A new command may start while the FIFO drains.
- **Return path:**
  - Each if_rddata_vld writes if_rddata into the FIFO with last = (rcv+1 == len).
  - It also does rcv++ and outstanding--.
  - A write and a read of the FIFO in the same cycle are both honoured; fifo_cnt is unchanged.
- **FIFO:**
  - FWFT. o_dat_vld = !empty.
  - A pop occurs on o_dat_vld & i_dat_rdy.
  - Overflow is impossible by construction. Verification asserts this.
- **Waitrequest:** waitrequest allowance is 0, i.e. standard waitrequest semantics.
- **Reset (any state, mid-burst included):**
  - FSM goes to IDLE; FIFO, counters and outstanding are cleared.
  - Read data returned after reset for pre-reset bursts is dropped. The interconnect must be reset together with this block.

## Timing
- Reset values:
  - o_cmd_rdy = 1, o_busy = 0, o_dat_vld = 0, o_dat_last = 0.
  - if_rd = 0, if_wr = 0, if_addr = 0, if_burst_c = 0, if_wrdata = 0, if_byteen = all ones.
  - o_dat is don't-care while o_dat_vld = 0; it is 0 out of reset.
- Command accepted in cycle T → if_rd high at T+1, provided credit is met.
- Back-to-back bursts: the next burst is asserted in the cycle after acceptance. Maximum issue rate is one burst per cycle while credit holds.
- if_rddata_vld in cycle T → beat visible on o_dat/o_dat_vld at T+1 when the FIFO was empty.
- Stream throughput is 1 beat/cycle with i_dat_rdy held high.
- DRAIN→IDLE: o_cmd_rdy rises the cycle after the last beat returns.
- Counter widths: rem and rcv are LEN_WIDTH. outstanding and fifo_cnt are clog2(FIFO_DEPTH)+1 and hold FIFO_DEPTH exactly. No wrap-around is permitted.
- Address arithmetic wraps modulo 2**ADDR_WIDTH; no error is flagged.

## Test plan
- addr=0x100, len=1, no waitreq → one read with if_addr=0x100, if_burst_c=1. One beat out with o_dat_last=1. o_cmd_rdy back high 1 cycle after the beat returns.
- addr=0x200, len=20 → bursts (0x200,8), (0x208,8), (0x210,4). 20 beats out in order; o_dat_last only on beat 20.
- if_waitreq held high 5 cycles on the second burst → if_rd, if_addr=0x208 and if_burst_c=8 stable across all 5 cycles. Exactly 3 bursts accepted in total.
- FIFO_DEPTH=16, i_dat_rdy=0, len=40 → exactly 2 bursts issued, then if_rd stays 0. Raising i_dat_rdy resumes issue; all 40 beats are delivered, no overflow.
- len=0 → command accepted in 1 cycle, no if_rd, o_busy stays 0.
- i_rst pulsed mid-burst with 3 beats outstanding → next cycle: IDLE, o_dat_vld=0, FIFO empty. A subsequent len=4 command completes normally.
